// File: rtl/vdrive_guard_pkg.sv
// Shared V-drive switch codes, phase numbering and fault codes.
// The vertical-drive controller and the guard both import this package.
package vdrive_pkg;

    // Switch code bit order: {pd, pul, puh, sel, seh, lss}
    localparam logic [5:0] C_L    = 6'b100000;
    localparam logic [5:0] C_LPE  = 6'b000100;   // also LNE
    localparam logic [5:0] C_M    = 6'b010000;   // M1 and M2
    localparam logic [5:0] C_HPE  = 6'b000011;   // also HNE
    localparam logic [5:0] C_H    = 6'b001001;
    localparam logic [5:0] C_DEAD = 6'b000000;

    typedef enum logic [2:0] {
        PH_L, PH_LPE, PH_M1, PH_HPE, PH_H, PH_HNE, PH_M2, PH_LNE
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_ILLEGAL    = 3'd1,
        FC_NO_DEAD    = 3'd2,
        FC_SEQ        = 3'd3,
        FC_SHORT_DEAD = 3'd4,
        FC_DEAD_TMO   = 3'd5,
        FC_H_OVER     = 3'd6
    } fault_e;

    // Switch code expected while sitting in a given phase
    function automatic logic [5:0] phase_code(input logic [2:0] idx);
        case (idx)
            3'd0:       phase_code = C_L;
            3'd1, 3'd7: phase_code = C_LPE;
            3'd2, 3'd6: phase_code = C_M;
            3'd3, 3'd5: phase_code = C_HPE;
            default:    phase_code = C_H;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] c);
        return c inside {C_L, C_LPE, C_M, C_HPE, C_H, C_DEAD};
    endfunction

endpackage

// File: rtl/vdrive_guard_if.sv
// Controller <-> guard <-> gate-driver signal bundle.
interface vdrive_guard_if #(parameter int CW = 16);
    logic          pd, pul, puh, sel, seh, lss;
    logic          fault_clr;
    logic          g_pd, g_pul, g_puh, g_sel, g_seh, g_lss;
    logic [2:0]    phase;
    logic          in_dead;
    logic          cycle_done;
    logic [CW-1:0] last_h_width;
    logic          fault;
    logic [2:0]    fault_code;

    modport master (
        output pd, pul, puh, sel, seh, lss, fault_clr,
        input  g_pd, g_pul, g_puh, g_sel, g_seh, g_lss,
        input  phase, in_dead, cycle_done, last_h_width, fault, fault_code
    );

    modport slave (
        input  pd, pul, puh, sel, seh, lss, fault_clr,
        output g_pd, g_pul, g_puh, g_sel, g_seh, g_lss,
        output phase, in_dead, cycle_done, last_h_width, fault, fault_code
    );
endinterface

// File: rtl/vdrive_guard_safe_seq.sv
// Shutdown sequencer: SAFE_DEAD all-off cycles starting on the fault rise,
// then pd clamped on for as long as the fault stays latched.
module vdrive_safe_seq
    import vdrive_pkg::*;
#(
    parameter int SAFE_DEAD = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_fault_rise,
    input  logic       i_clear,
    output logic [5:0] o_safe,
    output logic       o_safe_active
);
    localparam int CNT_W = (SAFE_DEAD > 1) ? $clog2(SAFE_DEAD) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Remaining all-off cycles after the one taken on the rise itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_fault_rise)
            r_cnt <= CNT_W'(SAFE_DEAD - 1);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_safe_active = i_fault_rise || (r_cnt != '0);
    assign o_safe        = o_safe_active ? C_DEAD : C_L;
endmodule

// File: rtl/vdrive_guard.sv
// Inline V-drive protection monitor: registers the controller code, tracks the
// phase sequence, checks deadtime / H on-time, latches the first fault and
// substitutes a safe shutdown sequence on the gate-driver outputs.
module vdrive_guard
    import vdrive_pkg::*;
#(
    parameter int MIN_DEAD  = 3,
    parameter int MAX_DEAD  = 16,
    parameter int MAX_H     = 200,
    parameter int SAFE_DEAD = 3,
    parameter int CW        = 16
) (
    input  logic clk,
    input  logic reset,
    vdrive_guard_if.slave bus
);
    localparam logic [CW-1:0] L_MIN_DEAD = CW'(MIN_DEAD);
    localparam logic [CW-1:0] L_MAX_DEAD = CW'(MAX_DEAD);
    localparam logic [CW-1:0] L_MAX_H    = CW'(MAX_H);

    logic [5:0]    r_in_q, r_g;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_dead_cnt, r_h_cnt, r_last_h;
    logic          r_fault, r_cycle_done;
    logic [2:0]    r_fcode;

    logic [5:0]    w_in, w_next_code, w_safe;
    logic [CW-1:0] w_dead_inc, w_h_inc;
    logic          w_hold, w_det, w_adv, w_clr, w_fault_next, w_safe_active;
    logic [2:0]    w_code;

    assign w_in        = {bus.pd, bus.pul, bus.puh, bus.sel, bus.seh, bus.lss};
    assign w_hold      = (r_in_q == phase_code(r_idx));
    assign w_next_code = phase_code(r_idx + 3'd1);
    assign w_dead_inc  = (&r_dead_cnt) ? r_dead_cnt : r_dead_cnt + CW'(1);
    assign w_h_inc     = (&r_h_cnt)    ? r_h_cnt    : r_h_cnt + CW'(1);
    // Clear only from a quiet L input; checks are off while faulted, so a
    // clear can never race a new detection here.
    assign w_clr        = r_fault && bus.fault_clr && (r_in_q == C_L);
    assign w_fault_next = w_det || (r_fault && !w_clr);

    // Violation checks on stage-1 code, branch order gives the fault priority
    always_comb begin
        w_det  = 1'b0;
        w_code = FC_NONE;
        w_adv  = 1'b0;
        if (!r_fault) begin
            if (!is_legal(r_in_q)) begin
                w_det = 1'b1; w_code = FC_ILLEGAL;
            end else if (r_in_q == C_DEAD) begin
                if (w_dead_inc > L_MAX_DEAD) begin
                    w_det = 1'b1; w_code = FC_DEAD_TMO;
                end
            end else if (w_hold) begin
                if (r_idx == PH_H && w_h_inc > L_MAX_H) begin
                    w_det = 1'b1; w_code = FC_H_OVER;
                end
            end else if (r_dead_cnt == '0) begin
                w_det = 1'b1; w_code = FC_NO_DEAD;
            end else if (r_in_q != w_next_code) begin
                w_det = 1'b1; w_code = FC_SEQ;
            end else if (r_dead_cnt < L_MIN_DEAD) begin
                w_det = 1'b1; w_code = FC_SHORT_DEAD;
            end else begin
                w_adv = 1'b1;
            end
        end
    end

    // Stage 1 input register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_in_q <= C_L;
        else       r_in_q <= w_in;
    end

    // Phase tracker: frozen while faulted, re-armed at L by a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= PH_L;
            r_dead_cnt   <= '0;
            r_h_cnt      <= '0;
            r_last_h     <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= w_adv && (r_idx == PH_LNE);
            if (w_clr) begin
                r_idx      <= PH_L;
                r_dead_cnt <= '0;
                r_h_cnt    <= '0;
            end else if (!r_fault && !w_det) begin
                if (r_in_q == C_DEAD) begin
                    r_dead_cnt <= w_dead_inc;
                    if (r_idx == PH_H && r_dead_cnt == '0)
                        r_last_h <= r_h_cnt;
                end else if (w_hold) begin
                    r_dead_cnt <= '0;
                    if (r_idx == PH_H)
                        r_h_cnt <= w_h_inc;
                end else if (w_adv) begin
                    r_idx      <= r_idx + 3'd1;
                    r_dead_cnt <= '0;
                    if (r_idx + 3'd1 == PH_H)
                        r_h_cnt <= CW'(1);
                end
            end
        end
    end

    // Fault latch: first detection wins and its code is frozen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
            r_fcode <= FC_NONE;
        end else if (w_det) begin
            r_fault <= 1'b1;
            r_fcode <= w_code;
        end else if (w_clr) begin
            r_fault <= 1'b0;
            r_fcode <= FC_NONE;
        end
    end

    vdrive_safe_seq #(.SAFE_DEAD(SAFE_DEAD)) u_safe (
        .clk           (clk),
        .reset         (reset),
        .i_fault_rise  (w_det),
        .i_clear       (w_clr),
        .o_safe        (w_safe),
        .o_safe_active (w_safe_active)
    );

    // Stage 2: the offending code is replaced before it reaches the drivers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_g <= C_L;
        else       r_g <= w_fault_next ? w_safe : r_in_q;
    end

    assign {bus.g_pd, bus.g_pul, bus.g_puh, bus.g_sel, bus.g_seh, bus.g_lss} = r_g;
    assign bus.phase        = r_idx;
    assign bus.in_dead      = (r_in_q == C_DEAD);
    assign bus.cycle_done   = r_cycle_done;
    assign bus.last_h_width = r_last_h;
    assign bus.fault        = r_fault;
    assign bus.fault_code   = r_fcode;
endmodule

// File: tb/tb_vdrive_guard.sv
// Directed-vector bench for vdrive_guard.
module tb_vdrive_guard;
    localparam logic [5:0] L   = 6'b100000;
    localparam logic [5:0] LP  = 6'b000100;
    localparam logic [5:0] M   = 6'b010000;
    localparam logic [5:0] HP  = 6'b000011;
    localparam logic [5:0] H   = 6'b001001;
    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] BAD = 6'b110000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [5:0] cur_c = L;
    logic [5:0] prev_c = L;
    logic [5:0] g;

    vdrive_guard_if bus ();

    vdrive_guard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign g = {bus.g_pd, bus.g_pul, bus.g_puh, bus.g_sel, bus.g_seh, bus.g_lss};

    // One clock with code c applied; afterwards g should show the previous code
    task automatic drive(input logic [5:0] c, input logic clr);
        {bus.pd, bus.pul, bus.puh, bus.sel, bus.seh, bus.lss} = c;
        bus.fault_clr = clr;
        @(posedge clk);
        #1;
        prev_c = cur_c;
        cur_c  = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {bus.pd, bus.pul, bus.puh, bus.sel, bus.seh, bus.lss} = L;
        bus.fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        cur_c  = L;
        prev_c = L;
    endtask

    task automatic walk_to_h();
        repeat (3) drive(Z, 1'b0);
        drive(LP, 1'b0);
        repeat (3) drive(Z, 1'b0);
        drive(M, 1'b0);
        repeat (3) drive(Z, 1'b0);
        drive(HP, 1'b0);
        repeat (3) drive(Z, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (g !== L) begin errs++; $display("FAIL reset g: got %b want %b", g, L); end
        vecs++; if (bus.phase !== 3'd0) begin errs++; $display("FAIL reset phase: got %0d want 0", bus.phase); end
        vecs++; if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin errs++; $display("FAIL reset fault: got %b/%0d want 0/0", bus.fault, bus.fault_code); end
        vecs++; if (bus.last_h_width !== 16'd0 || bus.cycle_done !== 1'b0 || bus.in_dead !== 1'b0) begin
            errs++; $display("FAIL reset misc: got hw=%0d cd=%b dead=%b want 0/0/0", bus.last_h_width, bus.cycle_done, bus.in_dead);
        end
    endtask

    task automatic test_nominal();
        logic [5:0] ph_c [8] = '{LP, M, HP, H, HP, M, LP, L};
        int         ph_n [8] = '{10, 100, 10, 50, 10, 100, 10, 4};
        int         pulses = 0;
        do_reset();
        drive(L, 1'b0);
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 3 + ph_n[s]; i++) begin
                logic [5:0] c;
                c = (i < 3) ? Z : ph_c[s];
                drive(c, 1'b0);
                pulses += int'(bus.cycle_done);
                vecs++; if (g !== prev_c) begin errs++; $display("FAIL nominal g seg%0d cyc%0d: got %b want %b", s, i, g, prev_c); end
                vecs++; if (bus.in_dead !== (c == Z)) begin errs++; $display("FAIL nominal in_dead seg%0d cyc%0d: got %b want %b", s, i, bus.in_dead, c == Z); end
            end
        end
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL nominal fault: got %b want 0", bus.fault); end
        vecs++; if (pulses != 1) begin errs++; $display("FAIL nominal cycle_done count: got %0d want 1", pulses); end
        vecs++; if (bus.last_h_width !== 16'd50) begin errs++; $display("FAIL nominal last_h_width: got %0d want 50", bus.last_h_width); end
        vecs++; if (bus.phase !== 3'd0) begin errs++; $display("FAIL nominal end phase: got %0d want 0", bus.phase); end
    endtask

    task automatic test_no_dead();
        logic [5:0] exp_g [4] = '{Z, Z, Z, L};
        do_reset();
        drive(L, 1'b0);
        drive(M, 1'b0);
        vecs++; if (g !== L) begin errs++; $display("FAIL no_dead g before: got %b want %b", g, L); end
        for (int i = 0; i < 4; i++) begin
            drive(L, 1'b0);
            vecs++; if (g !== exp_g[i]) begin errs++; $display("FAIL no_dead safe g[%0d]: got %b want %b", i, g, exp_g[i]); end
        end
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd2) begin errs++; $display("FAIL no_dead code: got %b/%0d want 1/2", bus.fault, bus.fault_code); end
    endtask

    task automatic test_deadtime();
        do_reset();
        drive(Z, 1'b0); drive(Z, 1'b0); drive(LP, 1'b0);
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL short_dead early: got %b want 0", bus.fault); end
        drive(Z, 1'b0);
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd4 || g !== Z) begin
            errs++; $display("FAIL short_dead: got %b/%0d g=%b want 1/4 g=000000", bus.fault, bus.fault_code, g);
        end
        do_reset();
        repeat (17) drive(Z, 1'b0);
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL dead_tmo early: got %b want 0", bus.fault); end
        drive(Z, 1'b0);
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd5) begin errs++; $display("FAIL dead_tmo: got %b/%0d want 1/5", bus.fault, bus.fault_code); end
    endtask

    task automatic test_illegal_seq();
        do_reset();
        drive(BAD, 1'b0);
        drive(L, 1'b0);
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd1 || g !== Z) begin
            errs++; $display("FAIL illegal: got %b/%0d g=%b want 1/1 g=000000", bus.fault, bus.fault_code, g);
        end
        do_reset();
        repeat (3) drive(Z, 1'b0);
        drive(LP, 1'b0);
        repeat (3) drive(Z, 1'b0);
        drive(HP, 1'b0);
        drive(L, 1'b0);
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd3) begin errs++; $display("FAIL seq: got %b/%0d want 1/3", bus.fault, bus.fault_code); end
    endtask

    task automatic test_h_over();
        do_reset();
        walk_to_h();
        for (int i = 0; i < 201; i++) begin
            drive(H, 1'b0);
            if (i == 4) begin
                vecs++; if (bus.phase !== 3'd4) begin errs++; $display("FAIL h phase: got %0d want 4", bus.phase); end
            end
        end
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL h_over early: got %b want 0", bus.fault); end
        drive(BAD, 1'b0);
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd6 || g !== Z) begin
            errs++; $display("FAIL h_over: got %b/%0d g=%b want 1/6 g=000000", bus.fault, bus.fault_code, g);
        end
        repeat (3) drive(L, 1'b0);
        vecs++; if (bus.fault_code !== 3'd6 || g !== L) begin errs++; $display("FAIL h_over frozen: got %0d g=%b want 6 g=100000", bus.fault_code, g); end
    endtask

    task automatic test_clear();
        do_reset();
        drive(M, 1'b0);
        drive(M, 1'b0);
        drive(M, 1'b1);
        drive(M, 1'b1);
        vecs++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd2) begin errs++; $display("FAIL clear at M1: got %b/%0d want 1/2", bus.fault, bus.fault_code); end
        drive(L, 1'b1);
        vecs++; if (bus.fault !== 1'b1) begin errs++; $display("FAIL clear before L: got %b want 1", bus.fault); end
        drive(L, 1'b1);
        vecs++; if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin errs++; $display("FAIL clear at L: got %b/%0d want 0/0", bus.fault, bus.fault_code); end
        drive(Z, 1'b0);
        vecs++; if (g !== L) begin errs++; $display("FAIL clear g: got %b want %b", g, L); end
        drive(Z, 1'b0); drive(Z, 1'b0); drive(LP, 1'b0); drive(LP, 1'b0);
        vecs++; if (g !== LP || bus.fault !== 1'b0) begin errs++; $display("FAIL clear resume: got g=%b f=%b want g=%b f=0", g, bus.fault, LP); end
    endtask

    task automatic test_reset_mid_h();
        do_reset();
        walk_to_h();
        repeat (5) drive(H, 1'b0);
        vecs++; if (g !== H) begin errs++; $display("FAIL mid_h g: got %b want %b", g, H); end
        #2;
        reset = 1'b1;
        #1;
        vecs++; if (g !== L || bus.phase !== 3'd0 || bus.fault !== 1'b0) begin
            errs++; $display("FAIL async reset: got g=%b ph=%0d f=%b want g=100000 ph=0 f=0", g, bus.phase, bus.fault);
        end
        do_reset();
    endtask

    initial begin
        bus.fault_clr = 1'b0;
        {bus.pd, bus.pul, bus.puh, bus.sel, bus.seh, bus.lss} = L;
        test_reset();
        test_nominal();
        test_no_dead();
        test_deadtime();
        test_illegal_seq();
        test_h_over();
        test_clear();
        test_reset_mid_h();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
